fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_ctrl.sv | 99 +++++++++
 tb/tb_fetch_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, queued {pc, instr} entry and queue sizing.
// Pure definitions; no latency and no backpressure of its own.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch queue with push/pop/flush; head visible combinationally, entries written on push.
// No internal backpressure: the caller only pushes when count<depth or a pop happens the same cycle.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  fetch_entry_t          push_dat,
  input  logic                  pop,
  input  logic                  flush,
  output fetch_entry_t          head_dat,
  output logic [FIFO_CNT_W-1:0] count
);

  fetch_entry_t          mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;

  // When full, push and pop share a slot: the head is read before the tail overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC, combinational ROM read, 2-deep queue; entry visible one cycle after fetch.
// Fetch stalls while the queue is full and not popping; redirect flushes and wins over halt and fault.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault,
  output logic [63:0] fault_pc
);

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [63:0]           pc;
  logic [FIFO_CNT_W-1:0] count;
  fetch_entry_t          head;
  fetch_entry_t          fetch_dat;
  logic                  addr_bad;
  logic                  fetch_try;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  set_fault;

  assign imem_addr = pc;
  assign fetch_dat = '{pc: pc, instr: imem_instr};
  assign addr_bad  = (pc[1:0] != 2'b00) || ((pc + 64'd3) >= 64'(MEM_SIZE));
  assign out_valid = (count != '0) && !redirect_valid;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fault     = (state == FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = halt ? HALTED : RUN;
    end else begin
      case (state)
        RUN: begin
          if (halt)           state_nxt = HALTED;
          else if (set_fault) state_nxt = FAULT;
        end
        HALTED:  if (!halt) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  // A fetch slot exists when the queue has room now or frees one this cycle.
  always_comb begin
    pop       = out_valid && out_ready;
    flush     = redirect_valid;
    fetch_try = (state == RUN) && !redirect_valid && !halt &&
                ((count < FIFO_CNT_W'(FIFO_DEPTH)) || pop);
    push      = fetch_try && !addr_bad;
    set_fault = fetch_try && addr_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else begin
      if (push)      pc       <= pc + 64'd4;
      if (set_fault) fault_pc <= pc;
    end
  end

  fetch_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (fetch_dat),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: hand-computed vector table, directed corner sequences, then random traffic
// checked against a queue-based reference model. ROM word i holds value i.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;
  logic [63:0] fault_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem_addr[33:2];

  fetch_ctrl #(.MEM_SIZE(1024), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [63:0] rpc, input logic h, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    out_ready      = rdy;
  endtask

  // Reference model: a queue of fetched entries plus a mode (0 run, 1 halted, 2 faulted).
  typedef struct packed { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc;
  int          m_mode;
  logic        m_fault;
  logic [63:0] m_fpc;

  function automatic logic [31:0] rom(input logic [63:0] a);
    return a[33:2];
  endfunction

  task automatic model_init();
    mq.delete();
    m_pc    = 64'h0;
    m_mode  = 0;
    m_fault = 1'b0;
    m_fpc   = 64'h0;
  endtask

  task automatic model_update(input logic rv, input logic [63:0] rpc, input logic h, input logic rdy);
    bit popped;
    bit slot;
    if (rv) begin
      mq.delete();
      m_pc    = rpc;
      m_mode  = h ? 1 : 0;
      m_fault = 1'b0;
    end else begin
      popped = (mq.size() > 0) && rdy;
      slot   = (m_mode == 0) && !h && ((mq.size() < 2) || popped);
      if (popped) void'(mq.pop_front());
      if (m_mode == 0 && h)       m_mode = 1;
      else if (m_mode == 1 && !h) m_mode = 0;
      if (slot) begin
        if ((m_pc % 4 != 0) || (m_pc > 64'd1020)) begin
          m_fault = 1'b1;
          m_fpc   = m_pc;
          m_mode  = 2;
        end else begin
          mq.push_back('{pc: m_pc, instr: rom(m_pc)});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  task automatic mstep(input logic rv, input logic [63:0] rpc, input logic h, input logic rdy);
    logic ev;
    drive(rv, rpc, h, rdy);
    @(negedge clk);
    ev = (mq.size() > 0) && !rv;
    chk("m_valid", out_valid, ev);
    chk("m_addr", imem_addr, m_pc);
    chk("m_fault", fault, m_fault);
    if (ev) begin
      chk("m_out_pc", out_pc, mq[0].pc);
      chk("m_out_instr", out_instr, mq[0].instr);
    end
    if (m_fault) chk("m_fault_pc", fault_pc, m_fpc);
    model_update(rv, rpc, h, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 64'h0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_addr", imem_addr, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        h;
    logic        rdy;
    logic        ev;
    logic [63:0] epc;
    logic [63:0] eaddr;
    logic        ef;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic        rv;
    logic        h;
    logic        rdy;
    logic [63:0] rpc;

    // {redirect, redirect_pc, halt, ready, exp_valid, exp_out_pc, exp_imem_addr, exp_fault}
    tbl = '{
      '{1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 64'h0,   64'h0,   1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b0, 1'b1, 64'h0,   64'h4,   1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b0, 1'b1, 64'h0,   64'h8,   1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b0, 1'b1, 64'h0,   64'h8,   1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b0, 1'b1, 64'h0,   64'h8,   1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h0,   64'h8,   1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h4,   64'hC,   1'b0},
      '{1'b1, 64'h100, 1'b0, 1'b1, 1'b0, 64'h0,   64'h10,  1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h0,   64'h100, 1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h100, 64'h104, 1'b0},
      '{1'b1, 64'h102, 1'b0, 1'b1, 1'b0, 64'h0,   64'h108, 1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h0,   64'h102, 1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h0,   64'h102, 1'b1},
      '{1'b1, 64'h0,   1'b1, 1'b1, 1'b0, 64'h0,   64'h102, 1'b1},
      '{1'b0, 64'h0,   1'b1, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 64'h0,   64'h0,   1'b0},
      '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 64'h0,   64'h4,   1'b0}
    };

    do_reset();

    // Table: saturation/ordering, redirect flush, misaligned redirect fault, halted redirect out of fault.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rv, tbl[i].rpc, tbl[i].h, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_fault", i), fault, tbl[i].ef);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_out_instr", i), out_instr, tbl[i].epc >> 2);
      end
      if (tbl[i].ef) chk($sformatf("tbl%0d_fault_pc", i), fault_pc, 64'h102);
      @(posedge clk);
      #1;
    end

    do_reset();

    // Streaming from reset with ready held high.
    for (int i = 0; i < 6; i++) mstep(1'b0, 64'h0, 1'b0, 1'b1);

    // Run off the end of memory, then redirect back to 0.
    mstep(1'b1, 64'h3F8, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) mstep(1'b0, 64'h0, 1'b0, 1'b1);
    chk("end_fault", fault, 1'b1);
    chk("end_fault_pc", fault_pc, 64'h400);
    chk("end_addr_held", imem_addr, 64'h400);
    chk("end_no_valid", out_valid, 1'b0);
    mstep(1'b0, 64'h0, 1'b1, 1'b1);
    chk("end_halt_ignored", fault, 1'b1);
    mstep(1'b1, 64'h0, 1'b0, 1'b1);
    chk("end_fault_cleared", fault, 1'b0);
    mstep(1'b0, 64'h0, 1'b0, 1'b1);

    // Halt at 0x10 for three cycles, then resume.
    mstep(1'b1, 64'h8, 1'b0, 1'b1);
    mstep(1'b0, 64'h0, 1'b0, 1'b1);
    mstep(1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) mstep(1'b0, 64'h0, 1'b1, 1'b1);
    chk("halt_pc_held", imem_addr, 64'h10);
    chk("halt_drained", out_valid, 1'b0);
    mstep(1'b0, 64'h0, 1'b0, 1'b1);
    mstep(1'b0, 64'h0, 1'b0, 1'b1);
    chk("resume_valid", out_valid, 1'b1);
    chk("resume_out_pc", out_pc, 64'h10);

    // Random traffic against the model.
    h = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) h = ~h;
      case ($urandom_range(0, 7))
        0:       rpc = 64'h3F0 + 64'($urandom_range(0, 3)) * 64'd4;
        1:       rpc = 64'($urandom_range(0, 1023));
        2:       rpc = 64'h400;
        default: rpc = 64'($urandom_range(0, 255)) << 2;
      endcase
      mstep(rv, rpc, h, rdy);
    end

    // Mid-run asynchronous reset with a redirect pending.
    mstep(1'b1, 64'h20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) mstep(1'b0, 64'h0, 1'b0, 1'b0);
    chk("pre_rst_valid", out_valid, 1'b1);
    drive(1'b1, 64'h200, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_addr", imem_addr, 64'h0);
    chk("async_rst_out_pc", out_pc, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
    for (int i = 0; i < 5; i++) mstep(1'b0, 64'h0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
